wm_control_panel: RTL and testbench
===================================

Name: wm_control_panel

Overview:
Front-panel controller sitting directly upstream of the washing machine FSM; it drives that FSM's start, double_wash, dry_wash and time_pause inputs and consumes its done output. It synchronises and debounces raw panel buttons and switches, then latches the program options at launch. It handshakes the start request against done, manages pause toggling and the door interlock, and flags a fault if the machine does not acknowledge a start.

Parameters:
DB_CYCLES, 4, consecutive stable samples required before a debounced input changes (min 1)
LAUNCH_TIMEOUT, 8, cycles in LAUNCH without done falling before FAULT (min 1)

Ports:
clk  in  1  single system clock, same clock as the washing machine FSM
rst  in  1  asynchronous, active-high reset
btn_start  in  1  raw start push-button, asynchronous
btn_pause  in  1  raw pause push-button, asynchronous
sw_double  in  1  raw double-wash selector switch
sw_dry  in  1  raw steam/dry-wash selector switch
door_closed  in  1  raw door sensor, 1 = closed
done  in  1  from machine FSM; 1 = machine idle/available
start  out  1  start request to machine
double_wash  out  1  latched double-wash option
dry_wash  out  1  latched steam-clean option
time_pause  out  1  pause request to machine
door_lock  out  1  door solenoid, 1 = locked
cycle_done  out  1  one-cycle pulse when a run completes
fault  out  1  machine failed to acknowledge start

Behaviour:
- Reset (async, rst=1): all outputs 0; FSM to IDLE; pause latch, option latches, timers and debouncer state cleared (debounced levels = 0).
- Inputs: each raw input passes a 2-flop synchroniser, then a debouncer. The debounced level updates only after DB_CYCLES consecutive equal synchronised samples that differ from the current level. A rise pulse is produced on each debounced 0->1 edge. Press-to-pulse latency is 2 + DB_CYCLES cycles.
- All outputs are registered.
- FSM states: IDLE, LAUNCH, RUN, FAULT.
- IDLE: door_lock=0, start=0, time_pause=0.
  - Start rise with door_closed=1 and done=1: latch dry_wash<=sw_dry and double_wash<=sw_double, clear pause latch and timer, go to LAUNCH.
  - Start rise while door open or done=0: ignored, stay IDLE.
- LAUNCH: start=1, door_lock=1, timer counts up each cycle.
  - done sampled 0: go to RUN next cycle, start deasserted from that cycle.
  - Timer reaches LAUNCH_TIMEOUT with done still 1: start<=0, fault<=1, go to FAULT.
  - done falling and timeout in the same cycle: done wins, go to RUN.
- RUN: door_lock=1; double_wash and dry_wash held constant, independent of switch changes.
  - Pause rise toggles the pause latch.
  - time_pause = pause_latch OR NOT door_closed_debounced. The door opening mid-run forces a pause; the latch itself is not modified.
  - done sampled 1: go to IDLE, pulse cycle_done for exactly one cycle, clear pause latch; time_pause, door_lock and options go to 0 on that transition.
  - Pause rise coinciding with done=1: completion wins and the pause latch is cleared.
- FAULT: fault=1, door_lock=0, start=0, time_pause=0. A start rise clears fault and returns to IDLE; it does not launch in the same press.
- Start rise in LAUNCH/RUN is ignored. Pause rise outside RUN is ignored.
- Reset mid-run: outputs drop asynchronously. Because the machine resets separately, the panel must not assume done state after reset; it waits in IDLE for a fresh start rise.
- Timer width: clog2(LAUNCH_TIMEOUT+1) bits, saturating, no wrap.

Decomposition:
- Shared package wm_pkg: FSM state enum (IDLE, LAUNCH, RUN, FAULT) and default DB_CYCLES / LAUNCH_TIMEOUT constants.
- Sub-module wm_debounce (parameter DB_CYCLES), instantiated five times. Each instance contains the synchroniser, stability counter, debounced level and rise pulse.

Test Plan:
- Reset then door closed, sw_double=1, press start for 10 cycles with the done model dropping 1 cycle after start -> start high exactly 2 cycles, door_lock=1, double_wash=1 held through the run; done back to 1 -> cycle_done single pulse, door_lock=0, double_wash=0.
- Start pressed with door_closed=0 -> start never asserts, state stays IDLE.
- done held at 1 after start -> after 8 LAUNCH cycles fault=1, start=0; a second start press -> fault=0, IDLE, no start pulse.
- RUN: two pause presses 20 cycles apart -> time_pause 1 then 0; door opened mid-run -> time_pause=1 while open, returns to latch value after close + debounce.
- Button bounce of 1-cycle glitches shorter than DB_CYCLES on btn_start -> no launch; a 6-cycle stable press -> exactly one launch.
- Toggle sw_dry during RUN -> dry_wash unchanged; assert rst mid-RUN -> all outputs 0 immediately, next start press launches normally.

Source files
------------

// File: rtl/wm_pkg.sv
// wm_pkg: shared types and defaults for the washing-machine front panel.
//   wm_state_e     - panel FSM state encoding
//   *_DEF          - default debounce length / launch timeout
//   IX_*           - slot of each raw panel input in the debouncer array
package wm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    FAULT  = 2'd3
  } wm_state_e;

  localparam int DB_CYCLES_DEF      = 4;
  localparam int LAUNCH_TIMEOUT_DEF = 8;

  localparam int NUM_IN    = 5;
  localparam int IX_START  = 0;
  localparam int IX_PAUSE  = 1;
  localparam int IX_DOUBLE = 2;
  localparam int IX_DRY    = 3;
  localparam int IX_DOOR   = 4;

endpackage

// File: rtl/wm_debounce.sv
// wm_debounce: 2-flop synchroniser followed by a stability-count debouncer.
//   clk, rst  - clock, async active-high reset (level and pulse clear to 0)
//   raw_i     - asynchronous raw input
//   level_o   - debounced level; changes after DB_CYCLES consecutive
//               synchronised samples that differ from the current level
//   rise_o    - one-cycle pulse, registered with the 0->1 level change
// Press-to-pulse latency is 2 + DB_CYCLES cycles.
module wm_debounce
  import wm_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  // Counter only has to reach DB_CYCLES-1.
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, rise_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      // Any sample equal to the current level restarts the count, so a
      // glitch shorter than DB_CYCLES never reaches the output.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_q <= sync2_q;
        rise_q  <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/wm_control_panel.sv
// wm_control_panel: front-panel controller for the washing-machine FSM.
//   clk, rst            - system clock, async active-high reset
//   btn_start/btn_pause - raw push-buttons (debounced, rise-triggered)
//   sw_double/sw_dry    - raw option switches, latched at launch
//   door_closed         - raw door sensor, 1 = closed
//   done                - machine idle/available (same clock domain)
//   start               - start request, held until done falls
//   double_wash/dry_wash- options latched for the duration of a run
//   time_pause          - pause request (pause latch or door open)
//   door_lock           - door solenoid, 1 = locked
//   cycle_done          - one-cycle pulse at run completion
//   fault               - machine did not acknowledge start in time
// All outputs are registered.
module wm_control_panel
  import wm_pkg::*;
#(
  parameter int DB_CYCLES      = DB_CYCLES_DEF,
  parameter int LAUNCH_TIMEOUT = LAUNCH_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_start,
  input  logic btn_pause,
  input  logic sw_double,
  input  logic sw_dry,
  input  logic door_closed,
  input  logic done,
  output logic start,
  output logic double_wash,
  output logic dry_wash,
  output logic time_pause,
  output logic door_lock,
  output logic cycle_done,
  output logic fault
);

  localparam int TW = $clog2(LAUNCH_TIMEOUT + 1);

  // ---- input conditioning ----
  logic [NUM_IN-1:0] raw_vec, lvl, rise;

  always_comb begin
    raw_vec            = '0;
    raw_vec[IX_START]  = btn_start;
    raw_vec[IX_PAUSE]  = btn_pause;
    raw_vec[IX_DOUBLE] = sw_double;
    raw_vec[IX_DRY]    = sw_dry;
    raw_vec[IX_DOOR]   = door_closed;
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_db
    wm_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (raw_vec[g]),
      .level_o(lvl[g]),
      .rise_o (rise[g])
    );
  end

  logic start_rise, pause_rise, dbl_db, dry_db, door_db;
  assign start_rise = rise[IX_START];
  assign pause_rise = rise[IX_PAUSE];
  assign dbl_db     = lvl[IX_DOUBLE];
  assign dry_db     = lvl[IX_DRY];
  assign door_db    = lvl[IX_DOOR];

  // Buttons are edge-only, switches/door are level-only.
  logic unused_db;
  assign unused_db = &{lvl[IX_START], lvl[IX_PAUSE],
                       rise[IX_DOUBLE], rise[IX_DRY], rise[IX_DOOR]};

  // ---- FSM ----
  wm_state_e     state_q;
  logic [TW-1:0] timer_q, timer_d;
  logic          pause_q, pause_d;
  logic          start_q, dbl_q, dry_q, tpause_q, lock_q, cdone_q, fault_q;

  // Saturating launch timer.
  assign timer_d = (timer_q == TW'(LAUNCH_TIMEOUT)) ? timer_q : timer_q + 1'b1;
  assign pause_d = pause_q ^ pause_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      pause_q  <= 1'b0;
      start_q  <= 1'b0;
      dbl_q    <= 1'b0;
      dry_q    <= 1'b0;
      tpause_q <= 1'b0;
      lock_q   <= 1'b0;
      cdone_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      cdone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_rise && door_db && done) begin
            state_q <= LAUNCH;
            start_q <= 1'b1;
            lock_q  <= 1'b1;
            dbl_q   <= dbl_db;
            dry_q   <= dry_db;
            pause_q <= 1'b0;
            timer_q <= '0;
          end
        end
        LAUNCH: begin
          timer_q <= timer_d;
          // Acknowledge takes priority over a coincident timeout.
          if (!done) begin
            state_q  <= RUN;
            start_q  <= 1'b0;
            tpause_q <= ~door_db;
          end else if (timer_d == TW'(LAUNCH_TIMEOUT)) begin
            state_q <= FAULT;
            start_q <= 1'b0;
            fault_q <= 1'b1;
            lock_q  <= 1'b0;
            dbl_q   <= 1'b0;
            dry_q   <= 1'b0;
          end
        end
        RUN: begin
          if (done) begin
            // Completion wins over a coincident pause press.
            state_q  <= IDLE;
            cdone_q  <= 1'b1;
            pause_q  <= 1'b0;
            tpause_q <= 1'b0;
            lock_q   <= 1'b0;
            dbl_q    <= 1'b0;
            dry_q    <= 1'b0;
          end else begin
            pause_q  <= pause_d;
            // An open door forces a pause without touching the latch.
            tpause_q <= pause_d | ~door_db;
          end
        end
        FAULT: begin
          // This press only acknowledges the fault; a new press launches.
          if (start_rise) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start       = start_q;
  assign double_wash = dbl_q;
  assign dry_wash    = dry_q;
  assign time_pause  = tpause_q;
  assign door_lock   = lock_q;
  assign cycle_done  = cdone_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_wm_control_panel.sv
// Directed bench for wm_control_panel (DB_CYCLES=4, LAUNCH_TIMEOUT=8).
// A small machine model drops done one cycle after seeing start and
// raises it again on request.
module tb_wm_control_panel;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_start = 1'b0, btn_pause = 1'b0, sw_double = 1'b0, sw_dry = 1'b0;
  logic door_closed = 1'b0;
  logic done;
  logic start, double_wash, dry_wash, time_pause, door_lock, cycle_done, fault;

  logic busy = 1'b0, auto_ack = 1'b1, finish_req = 1'b0;
  logic [6:0] outs;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  assign done = ~busy;
  always @(posedge clk) begin
    if (auto_ack && start) busy <= 1'b1;
    else if (finish_req)   busy <= 1'b0;
  end

  assign outs = {start, double_wash, dry_wash, time_pause, door_lock, cycle_done, fault};

  wm_control_panel #(.DB_CYCLES(4), .LAUNCH_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .btn_start(btn_start), .btn_pause(btn_pause),
    .sw_double(sw_double), .sw_dry(sw_dry),
    .door_closed(door_closed), .done(done),
    .start(start), .double_wash(double_wash), .dry_wash(dry_wash),
    .time_pause(time_pause), .door_lock(door_lock),
    .cycle_done(cycle_done), .fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press start, report negedges until start rises (0 = never), hold until
  // the machine acknowledges, release and let the button settle.
  task automatic launch(output int lat);
    lat = 0;
    btn_start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (start) begin lat = i; break; end
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!start) break;
    end
    btn_start = 1'b0;
    tick(8);
  endtask

  // Let the machine finish; expect exactly one cycle_done pulse.
  task automatic complete_run(input string tag);
    int n;
    n = 0;
    finish_req = 1'b1;
    @(negedge clk);
    finish_req = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (cycle_done) n++;
    end
    check(tag, n, 1);
  endtask

  initial begin
    int lat, n;
    logic seen, prev;

    // ---- reset ----
    tick(3);
    check("reset_outs", outs, 0);
    rst = 1'b0;
    door_closed = 1'b1;
    sw_double = 1'b1;
    tick(10);
    check("idle_outs", outs, 0);

    // ---- normal run with double wash ----
    btn_start = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (start) begin lat = i; break; end
    end
    check("launch_latency", lat, 7);
    check("launch_lock", door_lock, 1);
    check("launch_double", double_wash, 1);
    n = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (start) n++;
      else break;
    end
    check("start_width", n, 2);
    btn_start = 1'b0;
    tick(10);
    check("run_lock_opts", {door_lock, double_wash, dry_wash, time_pause}, 4'b1100);
    complete_run("run1_cycle_done");
    check("run1_idle_outs", outs, 0);

    // ---- start with door open is ignored ----
    door_closed = 1'b0;
    tick(8);
    seen = 1'b0;
    btn_start = 1'b1;
    for (int i = 0; i < 12; i++) begin @(negedge clk); seen |= start | door_lock; end
    btn_start = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); seen |= start | door_lock; end
    check("door_open_no_launch", seen, 0);
    door_closed = 1'b1;
    tick(8);

    // ---- no acknowledge -> fault ----
    auto_ack = 1'b0;
    btn_start = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (start) begin lat = i; break; end
    end
    check("fault_launch_latency", lat, 7);
    n = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (start) n++;
      else break;
    end
    check("timeout_start_width", n, 8);
    check("fault_outs", {fault, start, door_lock, time_pause}, 4'b1000);
    btn_start = 1'b0;
    tick(10);
    check("fault_held", fault, 1);
    btn_start = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!fault) begin lat = i; break; end
    end
    check("fault_clear_latency", lat, 7);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); seen |= start | fault; end
    btn_start = 1'b0;
    tick(8);
    check("fault_clear_no_launch", seen, 0);
    auto_ack = 1'b1;

    // ---- pause, door interlock, option hold ----
    sw_double = 1'b0;
    tick(8);
    launch(lat);
    check("run2_launch_latency", lat, 7);
    check("run2_no_pause", {time_pause, door_lock}, 2'b01);
    btn_pause = 1'b1; tick(8); btn_pause = 1'b0;
    check("pause_on", time_pause, 1);
    tick(12);
    btn_pause = 1'b1; tick(8); btn_pause = 1'b0;
    check("pause_off", time_pause, 0);
    door_closed = 1'b0;
    tick(8);
    check("door_open_forces_pause", {time_pause, door_lock}, 2'b11);
    door_closed = 1'b1;
    tick(8);
    check("door_close_restores", time_pause, 0);
    sw_dry = 1'b1;
    tick(8);
    check("dry_held_in_run", dry_wash, 0);
    complete_run("run2_cycle_done");
    btn_pause = 1'b1; tick(8); btn_pause = 1'b0; tick(8);
    check("idle_pause_ignored", outs, 0);

    // ---- bounce rejection, then one clean press ----
    sw_double = 1'b1;
    tick(8);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      btn_start = 1'b1; @(negedge clk); seen |= start;
      btn_start = 1'b0; @(negedge clk); seen |= start;
    end
    for (int i = 0; i < 12; i++) begin @(negedge clk); seen |= start; end
    check("bounce_no_launch", seen, 0);
    n = 0;
    prev = 1'b0;
    btn_start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 6) btn_start = 1'b0;
      if (start && !prev) n++;
      prev = start;
    end
    check("stable_press_one_launch", n, 1);
    check("run3_opts_latched", {double_wash, dry_wash, door_lock}, 3'b111);
    complete_run("run3_cycle_done");

    // ---- reset in the middle of a run ----
    launch(lat);
    check("run4_launch_latency", lat, 7);
    rst = 1'b1;
    #1;
    check("async_reset_outs", outs, 0);
    finish_req = 1'b1;
    tick(3);
    finish_req = 1'b0;
    rst = 1'b0;
    tick(10);
    check("post_reset_idle", outs, 0);
    launch(lat);
    check("post_reset_launch_latency", lat, 7);
    check("post_reset_opts", {double_wash, dry_wash, door_lock}, 3'b111);
    complete_run("run5_cycle_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
